// File: rtl/combo_lock_param.sv
// Parameterised combination lock with retry limit, timed lockout and in-field code reprogramming.
// The active code and the programming shadow both reload from CODE on every reset.
module combo_lock_param #(
  parameter int                    DIGITS      = 6,
  parameter int                    DW          = 4,
  parameter logic [DIGITS*DW-1:0]  CODE        = 24'h703262,
  parameter int                    MAX_TRIES   = 3,
  parameter int                    LOCK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] digit_in,
  input  logic          enter,
  input  logic          clear,
  input  logic          relock,
  input  logic          prog,
  output logic [2:0]    st,
  output logic [3:0]    pos,
  output logic [3:0]    fails,
  output logic          err
);

  localparam int LCW = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    OPEN    = 3'd1,
    CLOSED  = 3'd2,
    LOCKOUT = 3'd3,
    PROG    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           pos_q, pos_d;
  logic [3:0]           fails_q, fails_d;
  logic                 err_q, err_d;
  logic                 mism_q, mism_d;
  logic [LCW-1:0]       cnt_q, cnt_d;
  logic [DIGITS*DW-1:0] code_q, code_d;
  logic [DIGITS*DW-1:0] shadow_q, shadow_d;

  logic                 digit_ok;
  logic                 last;
  logic                 mism_new;
  logic [DW-1:0]        code_digit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      pos_q    <= '0;
      fails_q  <= '0;
      err_q    <= 1'b0;
      mism_q   <= 1'b0;
      cnt_q    <= '0;
      code_q   <= CODE;
      shadow_q <= CODE;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      fails_q  <= fails_d;
      err_q    <= err_d;
      mism_q   <= mism_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    fails_d    = fails_q;
    err_d      = 1'b0;
    mism_d     = mism_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    digit_ok   = (32'(digit_in) <= 32'd9);
    last       = (pos_q == 4'(DIGITS - 1));
    code_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_q == 4'(i)) code_digit = code_q[(DIGITS-1-i)*DW +: DW];
    end
    mism_new   = mism_q | (digit_in != code_digit);

    unique case (state_q)
      ENTRY: begin
        if (enter) begin
          if (!digit_ok) begin
            err_d = 1'b1;
          end else if (last) begin
            // The final digit is folded into the verdict in the same edge.
            pos_d  = '0;
            mism_d = 1'b0;
            if (!mism_new) begin
              state_d = OPEN;
              fails_d = '0;
            end else if (int'(fails_q) + 1 < MAX_TRIES) begin
              state_d = CLOSED;
              fails_d = fails_q + 4'd1;
            end else begin
              state_d = LOCKOUT;
              fails_d = 4'(MAX_TRIES);
              cnt_d   = LCW'(LOCK_CYCLES - 1);
            end
          end else begin
            pos_d  = pos_q + 4'd1;
            mism_d = mism_new;
          end
        end
      end
      CLOSED: begin
        if (clear) begin
          state_d = ENTRY;
          pos_d   = '0;
          mism_d  = 1'b0;
        end
      end
      LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = ENTRY;
          fails_d = '0;
          pos_d   = '0;
          mism_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OPEN: begin
        if (relock) begin
          state_d = ENTRY;
          pos_d   = '0;
          mism_d  = 1'b0;
        end else if (prog) begin
          state_d = PROG;
          pos_d   = '0;
        end
      end
      PROG: begin
        if (relock) begin
          state_d = ENTRY;
          pos_d   = '0;
          mism_d  = 1'b0;
        end else if (enter) begin
          if (!digit_ok) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (pos_q == 4'(i)) shadow_d[(DIGITS-1-i)*DW +: DW] = digit_in;
            end
            // Commit uses the shadow including this last digit, so the swap is atomic.
            if (last) begin
              code_d  = shadow_d;
              state_d = OPEN;
              pos_d   = '0;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end
        end
      end
      default: begin
        state_d = ENTRY;
        pos_d   = '0;
        mism_d  = 1'b0;
      end
    endcase
  end

  assign st    = 3'(state_q);
  assign pos   = pos_q;
  assign fails = fails_q;
  assign err   = err_q;

endmodule

// File: tb/tb_combo_lock_param.sv
// Bench for combo_lock_param: a default-parameter instance and a 4-digit 9999 instance,
// checked every cycle against a digit-list model plus directed literal expectations.
module tb_combo_lock_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enter, clear, relock, prog;
  logic [3:0] digit_in;
  logic [2:0] st;
  logic [3:0] pos, fails;
  logic       err;

  logic       rst_n_b, enter_b, clear_b, relock_b, prog_b;
  logic [3:0] digit_in_b;
  logic [2:0] st_b;
  logic [3:0] pos_b, fails_b;
  logic       err_b;

  int checks   = 0;
  int failures = 0;

  combo_lock_param dut_a (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .enter(enter), .clear(clear),
    .relock(relock), .prog(prog), .st(st), .pos(pos), .fails(fails), .err(err)
  );

  combo_lock_param #(
    .DIGITS(4), .DW(4), .CODE(16'h9999), .MAX_TRIES(3), .LOCK_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .digit_in(digit_in_b), .enter(enter_b), .clear(clear_b),
    .relock(relock_b), .prog(prog_b), .st(st_b), .pos(pos_b), .fails(fails_b), .err(err_b)
  );

  // Model keeps the typed digits and compares the whole attempt at once.
  typedef struct packed {
    int st;
    int pos;
    int fails;
    int err;
    int lock_left;
    logic [7:0][3:0] code;
    logic [7:0][3:0] shadow;
    logic [7:0][3:0] entered;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(input model_t m, input int d, input int mt, input int lc,
                                        input logic rst, input logic en, input int dig,
                                        input logic clr, input logic rl, input logic pg,
                                        input logic [31:0] init);
    model_t n;
    bit ok;
    bit match;
    n     = m;
    ok    = (dig <= 9);
    match = 1'b1;
    n.err = 0;
    if (rst) begin
      n.st = 0; n.pos = 0; n.fails = 0; n.lock_left = 0;
      n.code = '0;
      for (int i = 0; i < d; i++) n.code[i[2:0]] = init[(d-1-i)*4 +: 4];
      n.shadow = n.code;
      return n;
    end
    case (m.st)
      0: if (en) begin
        if (!ok) n.err = 1;
        else begin
          n.entered[n.pos[2:0]] = dig[3:0];
          n.pos = n.pos + 1;
          if (n.pos == d) begin
            for (int i = 0; i < d; i++) if (n.entered[i[2:0]] != n.code[i[2:0]]) match = 1'b0;
            n.pos = 0;
            if (match) begin n.st = 1; n.fails = 0; end
            else if (n.fails + 1 < mt) begin n.st = 2; n.fails = n.fails + 1; end
            else begin n.st = 3; n.fails = mt; n.lock_left = lc; end
          end
        end
      end
      1: if (rl) begin n.st = 0; n.pos = 0; end
         else if (pg) begin n.st = 4; n.pos = 0; end
      2: if (clr) begin n.st = 0; n.pos = 0; end
      3: begin
        n.lock_left = n.lock_left - 1;
        if (n.lock_left == 0) begin n.st = 0; n.fails = 0; n.pos = 0; end
      end
      4: if (rl) begin n.st = 0; n.pos = 0; end
         else if (en) begin
           if (!ok) n.err = 1;
           else begin
             n.shadow[n.pos[2:0]] = dig[3:0];
             n.pos = n.pos + 1;
             if (n.pos == d) begin n.code = n.shadow; n.st = 1; n.pos = 0; end
           end
         end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = model_step(ma, 6, 3, 16, !rst_n, enter, int'(digit_in), clear, relock, prog, 32'h00703262);
    mb = model_step(mb, 4, 3, 16, !rst_n_b, enter_b, int'(digit_in_b), clear_b, relock_b, prog_b,
                    32'h00009999);
    #1;
    checkOutput("cyc_st_a", int'(st), ma.st);
    checkOutput("cyc_pos_a", int'(pos), ma.pos);
    checkOutput("cyc_fails_a", int'(fails), ma.fails);
    checkOutput("cyc_err_a", int'(err), ma.err);
    checkOutput("cyc_st_b", int'(st_b), mb.st);
    checkOutput("cyc_pos_b", int'(pos_b), mb.pos);
    checkOutput("cyc_fails_b", int'(fails_b), mb.fails);
    checkOutput("cyc_err_b", int'(err_b), mb.err);
  end

  task automatic applyStimulus(input bit to_b, input logic rn, input logic en, input int dig,
                               input logic clr, input logic rl, input logic pg);
    @(negedge clk);
    rst_n = 1'b1; enter = 1'b0; digit_in = 4'd0; clear = 1'b0; relock = 1'b0; prog = 1'b0;
    rst_n_b = 1'b1; enter_b = 1'b0; digit_in_b = 4'd0; clear_b = 1'b0; relock_b = 1'b0; prog_b = 1'b0;
    if (to_b) begin
      rst_n_b = rn; enter_b = en; digit_in_b = dig[3:0]; clear_b = clr; relock_b = rl; prog_b = pg;
    end else begin
      rst_n = rn; enter = en; digit_in = dig[3:0]; clear = clr; relock = rl; prog = pg;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Enters n hex nibbles of code, most significant first, then leaves one idle cycle.
  task automatic enterCode(input bit to_b, input logic [31:0] code, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(to_b, 1'b1, 1'b1, int'(code[(n-1-i)*4 +: 4]), 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    int cnt;
    int dig;
    rst_n = 1'b0; enter = 1'b0; digit_in = 4'd0; clear = 1'b0; relock = 1'b0; prog = 1'b0;
    rst_n_b = 1'b0; enter_b = 1'b0; digit_in_b = 4'd0; clear_b = 1'b0; relock_b = 1'b0; prog_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst_n_b = 1'b1;
    checkOutput("rst_st", int'(st), 0);
    checkOutput("rst_pos", int'(pos), 0);
    checkOutput("rst_fails", int'(fails), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_st_b", int'(st_b), 0);

    enterCode(1'b0, 32'h703262, 6);
    checkOutput("good_code_st", int'(st), 1);
    checkOutput("good_code_model_st", ma.st, 1);
    checkOutput("good_code_fails", int'(fails), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    checkOutput("relock_st", int'(st), 0);

    enterCode(1'b0, 32'h703265, 6);
    checkOutput("bad_code_st", int'(st), 2);
    checkOutput("bad_code_fails", int'(fails), 1);
    checkOutput("bad_code_model_fails", ma.fails, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);
    idle();
    checkOutput("clear_st", int'(st), 0);
    checkOutput("clear_pos", int'(pos), 0);

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    enterCode(1'b0, 32'h111111, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    enterCode(1'b0, 32'h703265, 6);
    checkOutput("second_fail", int'(fails), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    enterCode(1'b0, 32'h000000, 6);
    checkOutput("lockout_st", int'(st), 3);
    checkOutput("lockout_fails", int'(fails), 3);
    cnt = 0;
    for (int i = 0; i < 40 && st == 3'd3; i++) begin
      cnt++;
      applyStimulus(1'b0, 1'b1, (i < 10), 5, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("lockout_cycles", cnt, 16);
    checkOutput("lockout_exit_st", int'(st), 0);
    checkOutput("lockout_exit_fails", int'(fails), 0);
    checkOutput("lockout_exit_pos", int'(pos), 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("bad_digit_err", int'(err), 1);
    checkOutput("bad_digit_pos", int'(pos), 2);
    idle();
    checkOutput("bad_digit_err_drop", int'(err), 0);
    enterCode(1'b0, 32'h3262, 4);
    checkOutput("after_bad_digit_st", int'(st), 1);

    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    enterCode(1'b0, 32'h123456, 6);
    checkOutput("prog_commit_st", int'(st), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    enterCode(1'b0, 32'h123456, 6);
    checkOutput("new_code_open", int'(st), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    enterCode(1'b0, 32'h123456, 6);
    checkOutput("code_after_reset_closed", int'(st), 2);
    checkOutput("code_after_reset_model", ma.st, 2);

    enterCode(1'b1, 32'h9999, 4);
    checkOutput("b_open", int'(st_b), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    enterCode(1'b1, 32'h12, 2);
    checkOutput("b_prog_pos", int'(pos_b), 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    enterCode(1'b1, 32'h9999, 4);
    checkOutput("b_abort_keeps_code", int'(st_b), 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      dig = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(ma.code[ma.pos[2:0]]);
      applyStimulus(1'b0, ($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), dig,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 5) == 0));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/combo_lock_param.md
COMBO_LOCK_PARAM -- requirements
Module: combo_lock_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIGITS, 6: code length in digits, 2..8.
- DW, 4: digit width in bits.
- CODE, 24'h703262: power-on code; digit 0 occupies the most significant DW bits.
- MAX_TRIES, 3: consecutive wrong codes before lockout, 1..15.
- LOCK_CYCLES, 16: lockout duration in clk cycles, at least 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: reset; synchronous, active-low.
- digit_in, in, DW: digit presented with enter.
- enter, in, 1: one-cycle strobe accepting digit_in.
- clear, in, 1: leave CLOSED.
- relock, in, 1: leave OPEN.
- prog, in, 1: request code reprogramming while OPEN.
- st, out, 3: state code; ENTRY=0, OPEN=1, CLOSED=2, LOCKOUT=3, PROG=4.
- pos, out, 4: digits accepted in the current sequence.
- fails, out, 4: consecutive failed attempts.
- err, out, 1: one-cycle pulse on a rejected digit.

Function
REQ-003 A digit SHALL be valid only when digit_in is 9 or less. An enter with an invalid digit SHALL pulse err in the next cycle and SHALL NOT change pos, the mismatch flag or the state.
REQ-004 In ENTRY, each valid enter SHALL compare digit_in against code digit pos, set a sticky mismatch flag on inequality, and increment pos.
REQ-005 The enter that brings pos to DIGITS SHALL evaluate the attempt using the mismatch result including that final digit:
- Match: go to OPEN; clear fails and pos.
- Mismatch with fails+1 < MAX_TRIES: go to CLOSED; fails increments; pos and the flag clear.
- Mismatch with fails+1 = MAX_TRIES: go to LOCKOUT; load the lockout counter with LOCK_CYCLES-1; fails saturates at MAX_TRIES.
REQ-006 The outcome SHALL be visible on st exactly one cycle after the final enter, with no extra latency.
REQ-007 In CLOSED, enter SHALL be ignored, and clear SHALL return the block to ENTRY with pos=0.
REQ-008 In LOCKOUT, all inputs SHALL be ignored. The counter SHALL decrement each cycle. On the cycle after the counter reads 0, the block SHALL enter ENTRY with fails=0. Total residence SHALL be exactly LOCK_CYCLES cycles.
REQ-009 In OPEN, the following SHALL apply:
- relock SHALL go to ENTRY.
- prog (without relock) SHALL go to PROG with pos=0.
- enter SHALL be ignored.
- If relock and prog are both asserted in the same cycle, relock SHALL win.
REQ-010 In PROG, each valid enter SHALL write digit_in into shadow slot pos and increment pos. The enter that fills slot DIGITS-1 SHALL commit the shadow to the code register atomically in the same edge and return to OPEN with pos=0.
REQ-011 relock asserted in PROG SHALL abort to ENTRY without altering the code register; a partial shadow SHALL never become active.
REQ-012 Simultaneous enter and clear in CLOSED SHALL act as clear only; the enter SHALL be dropped.
REQ-013 The block SHALL ignore enter held high for multiple cycles only if it is edge-qualified upstream; the block itself SHALL treat every enter-high cycle as a separate strobe.
REQ-014 The counters SHALL be sized as follows:
- pos SHALL count through DIGITS without wrap.
- fails SHALL saturate and never wrap.
- The lockout counter width SHALL be $clog2(LOCK_CYCLES)+1.

Reset
REQ-015 When rst_n=0 at a rising edge, the block SHALL reset as follows:
- st=ENTRY, pos=0, fails=0, err=0.
- Mismatch flag cleared.
- Lockout counter at 0.
- Code register and shadow loaded with CODE.
REQ-016 Reset SHALL take priority over every other input in every state, including mid-LOCKOUT and mid-PROG. A programmed code SHALL NOT survive reset.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Default params; enter 7,0,3,2,6,2 -> st=1 one cycle after the 6th enter; fails=0.
- Enter 7,0,3,2,6,5 -> st=2, fails=1. Then clear -> st=0, pos=0.
- Three wrong codes -> st=3 for exactly 16 cycles, then st=0 with fails=0. Enters during lockout change nothing.
- Enter digit 12 mid-sequence -> err pulses one cycle and pos is unchanged. The sequence then completes correctly -> OPEN.
- From OPEN: prog, then 1,2,3,4,5,6 -> st=1. Relock, then 1,2,3,4,5,6 -> OPEN. Reset, then 1,2,3,4,5,6 -> CLOSED.
- DIGITS=4, CODE=16'h9999; prog aborted by relock after 2 digits -> code remains 9999.
